// File: rtl/secuenciador_lectura_rtc_if.sv
// rtl/secuenciador_lectura_rtc_if.sv - RTC bus controller read handshake
// Purpose: groups the read request/acknowledge signals between the sweep
//   sequencer (master) and the RTC bus controller (slave).
// Signals:
//   rd_req   master->slave  read request, held until rd_ack or abandoned
//   rd_addr  master->slave  RTC register address
//   rd_ack   slave->master  read complete, rd_data valid this cycle
//   rd_data  slave->master  BCD byte {tens,units}
interface secuenciador_lectura_rtc_if;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/secuenciador_lectura_rtc.sv
// rtl/secuenciador_lectura_rtc.sv - RTC field sweep reader feeding the digit latch
// Purpose: sweeps the nine time/date/timer fields, reads each from the RTC,
//   splits the BCD byte into units/tens and strobes it out with its index.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   escribiendo   user write mode; suppresses sweeping and strobes
//   bus           read handshake to the RTC bus controller (master side)
//   direccion     field index 0..8
//   dig1_Unit/Dec units/tens nibble of last captured field
//   en_out        one-cycle strobe, direccion/dig1_* valid
//   barrido_fin   one-cycle pulse after field 8
//   error_to      sticky read timeout flag
//   bcd_err       pulses with en_out when a nibble was > 9
module secuenciador_lectura_rtc #(
  parameter logic [15:0] PAUSA   = 16'd1000,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              escribiendo,
  secuenciador_lectura_rtc_if.master        bus,
  output logic [3:0]                        direccion,
  output logic [3:0]                        dig1_Unit,
  output logic [3:0]                        dig1_Dec,
  output logic                              en_out,
  output logic                              barrido_fin,
  output logic                              error_to,
  output logic                              bcd_err
);

  typedef enum logic [1:0] {ESPERA, PEDIR, CAPTURA, SIGUIENTE} estado_t;

  estado_t     estado_q, estado_d;
  logic [15:0] pausa_q, pausa_d;
  logic [7:0]  to_q, to_d;
  logic [3:0]  dir_q, dir_d;
  logic [7:0]  dato_q, dato_d;
  logic [3:0]  unit_q, unit_d;
  logic [3:0]  dec_q, dec_d;
  logic        error_q, error_d;

  logic [3:0]  unit_nuevo, dec_nuevo;
  logic        nibble_malo;

  // Out-of-range BCD nibbles are forced to zero rather than passed through.
  assign unit_nuevo  = (dato_q[3:0] > 4'd9) ? 4'h0 : dato_q[3:0];
  assign dec_nuevo   = (dato_q[7:4] > 4'd9) ? 4'h0 : dato_q[7:4];
  assign nibble_malo = (dato_q[3:0] > 4'd9) || (dato_q[7:4] > 4'd9);

  assign direccion = dir_q;
  assign error_to  = error_q;

  always_comb begin
    bus.rd_addr = 8'h00;
    case (dir_q)
      4'd0: bus.rd_addr = 8'h23;
      4'd1: bus.rd_addr = 8'h22;
      4'd2: bus.rd_addr = 8'h21;
      4'd3: bus.rd_addr = 8'h25;
      4'd4: bus.rd_addr = 8'h24;
      4'd5: bus.rd_addr = 8'h26;
      4'd6: bus.rd_addr = 8'h43;
      4'd7: bus.rd_addr = 8'h42;
      4'd8: bus.rd_addr = 8'h41;
      default: bus.rd_addr = 8'h00;
    endcase
  end

  always_comb begin
    estado_d    = estado_q;
    pausa_d     = pausa_q;
    to_d        = to_q;
    dir_d       = dir_q;
    dato_d      = dato_q;
    unit_d      = unit_q;
    dec_d       = dec_q;
    error_d     = error_q;
    bus.rd_req  = 1'b0;
    en_out      = 1'b0;
    barrido_fin = 1'b0;
    bcd_err     = 1'b0;
    // Digits come straight from the decoder during the strobe cycle so they
    // are valid together with en_out, then are held from the registers.
    dig1_Unit   = unit_q;
    dig1_Dec    = dec_q;

    case (estado_q)
      ESPERA: begin
        if (escribiendo) begin
          pausa_d = PAUSA;
        end else if (pausa_q <= 16'd1) begin
          pausa_d  = 16'd0;
          estado_d = PEDIR;
        end else begin
          pausa_d = pausa_q - 16'd1;
        end
      end
      PEDIR: begin
        // An outstanding read always finishes (ack or timeout), even if
        // escribiendo rises meanwhile.
        bus.rd_req = 1'b1;
        if (bus.rd_ack) begin
          dato_d   = bus.rd_data;
          to_d     = 8'd0;
          estado_d = CAPTURA;
        end else if (to_q == TIMEOUT - 8'd1) begin
          to_d     = 8'd0;
          error_d  = 1'b1;
          estado_d = SIGUIENTE;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      CAPTURA: begin
        if (escribiendo) begin
          pausa_d  = PAUSA;
          estado_d = ESPERA;
        end else begin
          en_out    = 1'b1;
          bcd_err   = nibble_malo;
          dig1_Unit = unit_nuevo;
          dig1_Dec  = dec_nuevo;
          unit_d    = unit_nuevo;
          dec_d     = dec_nuevo;
          error_d   = 1'b0;
          estado_d  = SIGUIENTE;
        end
      end
      SIGUIENTE: begin
        if (dir_q == 4'd8) begin
          dir_d       = 4'd0;
          barrido_fin = 1'b1;
          pausa_d     = PAUSA;
          estado_d    = ESPERA;
        end else begin
          dir_d    = dir_q + 4'd1;
          estado_d = PEDIR;
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= ESPERA;
      pausa_q  <= PAUSA;
      to_q     <= 8'd0;
      dir_q    <= 4'd0;
      dato_q   <= 8'd0;
      unit_q   <= 4'd0;
      dec_q    <= 4'd0;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pausa_q  <= pausa_d;
      to_q     <= to_d;
      dir_q    <= dir_d;
      dato_q   <= dato_d;
      unit_q   <= unit_d;
      dec_q    <= dec_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_secuenciador_lectura_rtc.sv
// tb/tb_secuenciador_lectura_rtc.sv - scoreboard bench for the RTC sweep reader
module tb_secuenciador_lectura_rtc;
  logic       clk;
  logic       reset;
  logic       escribiendo;
  logic [3:0] direccion, dig1_Unit, dig1_Dec;
  logic       en_out, barrido_fin, error_to, bcd_err;

  secuenciador_lectura_rtc_if bus ();

  secuenciador_lectura_rtc #(.PAUSA(16'd4), .TIMEOUT(8'd8)) dut (
    .clk         (clk),
    .reset       (reset),
    .escribiendo (escribiendo),
    .bus         (bus),
    .direccion   (direccion),
    .dig1_Unit   (dig1_Unit),
    .dig1_Dec    (dig1_Dec),
    .en_out      (en_out),
    .barrido_fin (barrido_fin),
    .error_to    (error_to),
    .bcd_err     (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int barr_cnt = 0;
  logic [12:0] sb[$];
  logic [12:0] e_mon;
  logic [7:0] addr_tab [0:8] = '{8'h23, 8'h22, 8'h21, 8'h25, 8'h24, 8'h26, 8'h43, 8'h42, 8'h41};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per strobe, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (en_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_en_out actual=dir%0d required=no_strobe", direccion);
      end else begin
        e_mon = sb.pop_front();
        chk("strobe_dir_unit_dec_bcderr", {3'b0, direccion, dig1_Unit, dig1_Dec, bcd_err}, {3'b0, e_mon});
      end
    end else if (bcd_err) begin
      chk("bcd_err_without_en_out", bcd_err, 1'b0);
    end
    if (barrido_fin) barr_cnt++;
  end

  task automatic wait_req(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.rd_req) break;
    end
    if (!bus.rd_req) begin
      total++;
      bad++;
      $display("FAIL wait_req actual=no_req required=rd_req_within_100_cycles");
    end
  endtask

  // Called at the negedge where rd_req was first seen; acks after dly cycles.
  task automatic do_ack(input logic [3:0] dir, input logic [7:0] data, input int dly,
                        input logic [3:0] eu, input logic [3:0] ed, input logic ebe);
    chk("rd_addr", {8'h0, bus.rd_addr}, {8'h0, addr_tab[dir]});
    chk("direccion_at_req", {12'h0, direccion}, {12'h0, dir});
    repeat (dly) @(negedge clk);
    sb.push_back({dir, eu, ed, ebe});
    bus.rd_data = data;
    bus.rd_ack  = 1'b1;
    @(negedge clk);
    bus.rd_ack  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    logic saw_req;
    reset = 1'b0;
    escribiendo = 1'b0;
    bus.rd_ack = 1'b0;
    bus.rd_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_rd_req", bus.rd_req, 1'b0);
    chk("reset_direccion", direccion, 4'd0);
    chk("reset_unit", dig1_Unit, 4'd0);
    chk("reset_dec", dig1_Dec, 4'd0);
    chk("reset_en_out", en_out, 1'b0);
    chk("reset_error_to", error_to, 1'b0);
    chk("reset_barrido_bcd", {barrido_fin, bcd_err}, 2'b00);
    reset = 1'b1;

    // Full sweep with data 0x37
    for (int i = 0; i < 9; i++) begin
      wait_req(n);
      if (i > 0) chk("gap_next_req", n, 16'd2);
      do_ack(i[3:0], 8'h37, 2, 4'd7, 4'd3, 1'b0);
    end
    wait_req(n);
    chk("pause_after_sweep", n, 16'd6);
    chk("barrido_count1", barr_cnt, 16'd1);

    // Second sweep: assorted patterns
    do_ack(4'd0, 8'h12, 1, 4'd2, 4'd1, 1'b0);
    wait_req(n);
    do_ack(4'd1, 8'hA5, 2, 4'd5, 4'd0, 1'b1);
    wait_req(n);
    do_ack(4'd2, 8'h59, 0, 4'd9, 4'd5, 1'b0);
    chk("lat_en_out", en_out, 1'b1);
    chk("lat_rd_req", bus.rd_req, 1'b0);
    chk("lat_unit", dig1_Unit, 4'd9);
    chk("lat_dec", dig1_Dec, 4'd5);
    @(negedge clk);
    chk("strobe_one_cycle", en_out, 1'b0);
    chk("unit_held", dig1_Unit, 4'd9);
    wait_req(n);
    chk("req_k_plus_3", n, 16'd1);
    do_ack(4'd3, 8'h31, 3, 4'd1, 4'd3, 1'b0);

    // Timeout at direccion 4
    wait_req(n);
    chk("to_rd_addr", bus.rd_addr, 8'h24);
    hi = 1;
    while (bus.rd_req && hi < 50) begin
      @(negedge clk);
      if (bus.rd_req) hi++;
    end
    chk("timeout_len", hi, 16'd8);
    chk("timeout_error_to", error_to, 1'b1);
    wait_req(n);
    chk("error_to_sticky", error_to, 1'b1);
    do_ack(4'd5, 8'h27, 2, 4'd7, 4'd2, 1'b0);
    @(negedge clk);
    chk("error_to_cleared", error_to, 1'b0);

    // escribiendo raised during PEDIR at direccion 6
    wait_req(n);
    chk("esc_rd_addr", bus.rd_addr, 8'h43);
    escribiendo = 1'b1;
    repeat (2) @(negedge clk);
    bus.rd_data = 8'h88;
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    chk("esc_no_strobe", en_out, 1'b0);
    chk("esc_dir_held", direccion, 4'd6);
    chk("esc_digits_held", {dig1_Dec, dig1_Unit}, 8'h27);
    saw_req = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rd_req) saw_req = 1'b1;
    end
    chk("esc_paused", saw_req, 1'b0);
    escribiendo = 1'b0;
    wait_req(n);
    chk("esc_resume_delay", n, 16'd4);
    do_ack(4'd6, 8'h15, 1, 4'd5, 4'd1, 1'b0);
    wait_req(n);
    do_ack(4'd7, 8'h9F, 2, 4'd0, 4'd9, 1'b1);
    wait_req(n);
    do_ack(4'd8, 8'h00, 2, 4'd0, 4'd0, 1'b0);

    // Third sweep up to direccion 5, then reset mid-request
    for (int i = 0; i < 5; i++) begin
      wait_req(n);
      do_ack(i[3:0], 8'h44, 1, 4'd4, 4'd4, 1'b0);
    end
    wait_req(n);
    chk("pre_reset_rd_addr", bus.rd_addr, 8'h26);
    reset = 1'b0;
    #1;
    chk("async_rd_req", bus.rd_req, 1'b0);
    chk("async_direccion", direccion, 4'd0);
    chk("async_digits", {dig1_Dec, dig1_Unit}, 8'h00);
    chk("async_flags", {en_out, barrido_fin, error_to, bcd_err}, 4'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_req(n);
    do_ack(4'd0, 8'h61, 2, 4'd1, 4'd6, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 16'd0);
    chk("barrido_count2", barr_cnt, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
